// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a requester and the sequential binary-to-BCD converter.
// The ovf wire only exists when BIN2BCD_OVF_EN is defined.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  valid;
`ifdef BIN2BCD_OVF_EN
  logic                  ovf;

  modport master (output start, output bin,
                  input  bcd, input busy, input valid, input ovf);
  modport slave  (input  start, input bin,
                  output bcd, output busy, output valid, output ovf);
`else
  modport master (output start, output bin,
                  input  bcd, input busy, input valid);
  modport slave  (input  start, input bin,
                  output bcd, output busy, output valid);
`endif

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Optional overflow flag compiled in when BIN2BCD_OVF_EN is defined.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] bin_q,     bin_d;
  logic [BCDW-1:0]  scratch_q, scratch_d;
  logic [BCDW-1:0]  bcd_q,     bcd_d;
  logic [CW-1:0]    cnt_q,     cnt_d;

  logic [BCDW-1:0]  adj;
  logic [BCDW-1:0]  next_scratch;
  logic             last_bit;

  // Digits >= 5 get +3 so the following shift carries correctly into the next digit.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Anything shifted out of the top digit is dropped, which leaves bin mod 10^DIGITS.
  assign next_scratch = BCDW'({adj, bin_q[WIDTH-1]});
  assign last_bit     = (cnt_q == CW'(1));

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          bin_d     = bus.bin;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
        end
      end
      SHIFT: begin
        scratch_d = next_scratch;
        bin_d     = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CW'(1);
        if (last_bit) begin
          state_d = DONE;
          bcd_d   = next_scratch;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.busy  = (state_q == SHIFT);
  assign bus.valid = (state_q == DONE);

`ifdef BIN2BCD_OVF_EN
  logic carry;
  logic ovf_acc_q, ovf_acc_d;
  logic ovf_q,     ovf_d;

  // A 1 leaving the top corrected digit means the value has passed 10^DIGITS-1.
  assign carry = adj[BCDW-1];

  always_comb begin
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
    if (state_q == IDLE && bus.start) begin
      ovf_acc_d = 1'b0;
    end else if (state_q == SHIFT) begin
      ovf_acc_d = ovf_acc_q | carry;
      if (last_bit) begin
        ovf_d = ovf_acc_q | carry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 8: binary input width in bits; legal range 4..16.
REQ-002 Parameter DIGITS, default 3: number of BCD output digits; legal range 1..5.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: conversion request; sampled only while idle.
REQ-006 Port bin, input, WIDTH: binary value to convert (the upstream counter's count); sampled with start.
REQ-007 Port bcd, output, 4*DIGITS: packed BCD result; digit 0 (units) in bits [3:0].
REQ-008 Port busy, output, 1: high while a conversion is in progress.
REQ-009 Port valid, output, 1: one-cycle pulse marking bcd newly updated.
REQ-010 Port ovf, output, 1: present only when BIN2BCD_OVF_EN is defined (see Configuration).

Function
REQ-011 The block SHALL implement iterative shift-add-3 (double dabble), one bit per clock.
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL latch bin, clear the scratch BCD register, load a bit counter with WIDTH, and enter SHIFT.
REQ-014 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-015 In SHIFT, each edge SHALL add 3 to every scratch digit >= 5, then shift {scratch, bin_reg} left by one, and decrement the bit counter.
REQ-016 The SHIFT-to-DONE transition SHALL occur on the edge where the bit counter reaches 0, i.e. edge E_WIDTH.
REQ-017 On that same edge E_WIDTH, bcd SHALL be loaded from the final scratch value.
REQ-018 valid SHALL be high for exactly the one cycle following E_WIDTH (state DONE); DONE SHALL return to IDLE unconditionally on the next edge.
REQ-019 busy SHALL be high in every cycle from after E0 up to and including the cycle before DONE.
REQ-020 busy SHALL be low in IDLE and in DONE.
REQ-021 start while busy is high or in DONE SHALL be ignored, with no queuing.
REQ-022 start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a back-to-back period of WIDTH+2 cycles.
REQ-023 bcd SHALL hold the last completed result until the next completion; it SHALL never show intermediate scratch values.
REQ-024 Changes on bin after E0 SHALL not affect the conversion in progress.
REQ-025 If bin exceeds 10^DIGITS-1, bcd SHALL equal bin mod 10^DIGITS, with every digit in 0..9.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, bcd=0, busy=0, valid=0, ovf=0, and clear the scratch register and bit counter.
REQ-027 rst asserted mid-conversion SHALL abort it with no valid pulse; the first start after rst deasserts SHALL begin a fresh conversion.

Configuration
REQ-028 Macro BIN2BCD_OVF_EN SHALL control the ovf feature.
REQ-029 With BIN2BCD_OVF_EN defined: port ovf exists and a carry-out detector on the scratch register's top digit is compiled in.
REQ-030 With BIN2BCD_OVF_EN defined: ovf SHALL be registered with bcd at E_WIDTH, and SHALL be 1 iff the converted value exceeded 10^DIGITS-1.
REQ-031 With BIN2BCD_OVF_EN defined: ovf SHALL hold until the next completion or reset.
REQ-032 Without BIN2BCD_OVF_EN: port ovf and its logic SHALL be absent; bcd behaviour is unchanged (modulo per REQ-025).

Verification
REQ-033 Defaults; bin=8'd255, start pulse at E0 -> busy high 8 cycles, valid single pulse after E8, bcd=12'h255.
REQ-034 bin=0 then bin=99, back-to-back starts -> bcd=12'h000 then 12'h099, valid pulses exactly 10 cycles apart.
REQ-035 start held high throughout conversion of 8'd123 -> exactly one valid per accepted start, bcd=12'h123, no extra acceptance while busy.
REQ-036 rst pulsed at cycle 4 of a conversion of 8'd200 -> no valid, bcd=0; the next start with 8'd7 yields bcd=12'h007.
REQ-037 BIN2BCD_OVF_EN defined, DIGITS=2, bin=8'd255 -> bcd=8'h55, ovf=1; then bin=8'd42 -> bcd=8'h42, ovf=0.
REQ-038 bin changed to 8'd0 on the cycle after E0 of a conversion of 8'd64 -> bcd=12'h064.
